// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA channel arbiter slice.
//   - arbiter state encoding
//   - default address / word-count widths
//   - byte stride of one DMA word
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    COMPLETE  = 2'd3
  } state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int LEN_W_DEF   = 32;
  localparam int WORD_STRIDE = 4;  // bytes per DMA word

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req   : request vector, one bit per channel
//   ptr   : index with highest priority this round
//   valid : at least one request present
//   idx   : first requesting index scanning ptr, ptr+1, ... mod NUM_CH
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  logic [31:0] cand;

  // Scan from the farthest offset down to offset 0 so the nearest
  // requester to ptr is the last (winning) assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = (32'(ptr) + 32'(off)) % 32'(NUM_CH);
      if (req[cand[IDX_W-1:0]]) idx = cand[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/dma_chan_arbiter.sv
// dma_chan_arbiter: multi-channel round-robin front end for a single DMA
// copy engine. Picks one requesting channel, loads its descriptor into the
// engine, pulses start, waits for done and reports completion to the channel.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   ch_req/ch_src/ch_dest/ch_len  per-channel request + packed descriptors
//   ch_grant                   one-hot channel being served
//   ch_done/ch_err             one-cycle completion / error pulses
//   dma_start/src/dest/len     engine command outputs
//   dma_busy/dma_done          engine status inputs
//   arb_busy                   arbiter not idle
//
// Build option: DMA_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT_CYC
// cycles that completes the transfer with an error.
//
// All outputs are flops. Output flops are loaded from the *next* state, so
// ch_done/ch_err are visible while the state register holds COMPLETE and
// ch_grant drops as the arbiter returns to IDLE.
module dma_chan_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dest,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     dma_start,
  output logic [ADDR_W-1:0]        dma_src,
  output logic [ADDR_W-1:0]        dma_dest,
  output logic [LEN_W-1:0]         dma_len,
  input  logic                     dma_busy,
  input  logic                     dma_done,
  output logic                     arb_busy
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Unpacked per-channel descriptor views.
  logic [NUM_CH-1:0][ADDR_W-1:0] src_a, dest_a;
  logic [NUM_CH-1:0][LEN_W-1:0]  len_a;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign src_a[i]  = ch_src[i*ADDR_W +: ADDR_W];
    assign dest_a[i] = ch_dest[i*ADDR_W +: ADDR_W];
    assign len_a[i]  = ch_len[i*LEN_W +: LEN_W];
  end

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   errp_q, errp_d;
  logic                start_q, start_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                arb_busy_q, arb_busy_d;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req   (ch_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State register (plus all datapath/output flops).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      errp_q     <= '0;
      start_q    <= 1'b0;
      src_q      <= '0;
      dest_q     <= '0;
      len_q      <= '0;
      arb_busy_q <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      errp_q     <= errp_d;
      start_q    <= start_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      len_q      <= len_d;
      arb_busy_q <= arb_busy_d;
`ifdef DMA_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Zero-length descriptors bypass the engine entirely.
        if (pick_valid && !dma_busy)
          state_d = (len_a[pick_idx] != '0) ? ISSUE : COMPLETE;
      end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (dma_done) state_d = COMPLETE;
`ifdef DMA_ARB_TIMEOUT_EN
        else if (timeout) state_d = COMPLETE;
`endif
      end
      COMPLETE:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    grant_d  = grant_q;
    done_d   = '0;
    errp_d   = '0;
    start_d  = 1'b0;
    src_d    = src_q;
    dest_d   = dest_q;
    len_d    = len_q;
`ifdef DMA_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (state_d != IDLE) begin
          idx_d            = pick_idx;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          src_d            = src_a[pick_idx];
          dest_d           = dest_a[pick_idx];
          len_d            = len_a[pick_idx];
          err_d            = (state_d == COMPLETE);
          start_d          = (state_d == ISSUE);
        end
      end
      ISSUE: begin
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (!dma_done && timeout) err_d = 1'b1;
`endif
      end
      COMPLETE: begin
        grant_d  = '0;
        rr_ptr_d = (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
    // Completion pulses are loaded on the edge that enters COMPLETE.
    if (state_q != COMPLETE && state_d == COMPLETE) begin
      done_d[idx_d] = 1'b1;
      errp_d[idx_d] = err_d;
    end
  end

  assign arb_busy_d = (state_d != IDLE);

  assign ch_grant  = grant_q;
  assign ch_done   = done_q;
  assign ch_err    = errp_q;
  assign dma_start = start_q;
  assign dma_src   = src_q;
  assign dma_dest  = dest_q;
  assign dma_len   = len_q;
  assign arb_busy  = arb_busy_q;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Directed self-checking bench for dma_chan_arbiter (NUM_CH=4, 32-bit).
// Inputs change 1 time unit after each rising edge; outputs are checked then.
module tb_dma_chan_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int LW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_src, ch_dest;
  logic [NCH*LW-1:0] ch_len;
  logic [NCH-1:0]    ch_grant, ch_done, ch_err;
  logic              dma_start, dma_busy, dma_done, arb_busy;
  logic [AW-1:0]     dma_src, dma_dest;
  logic [LW-1:0]     dma_len;

  int vectors    = 0;
  int miscompares = 0;

  dma_chan_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_src(ch_src), .ch_dest(ch_dest),
    .ch_len(ch_len), .ch_grant(ch_grant), .ch_done(ch_done), .ch_err(ch_err),
    .dma_start(dma_start), .dma_src(dma_src), .dma_dest(dma_dest),
    .dma_len(dma_len), .dma_busy(dma_busy), .dma_done(dma_done),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_grant"}, 64'(ch_grant), 64'h0);
    chk({tag, "_done"},  64'(ch_done),  64'h0);
    chk({tag, "_err"},   64'(ch_err),   64'h0);
    chk({tag, "_start"}, 64'(dma_start), 64'h0);
    chk({tag, "_busy"},  64'(arb_busy), 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ch_req = '0; ch_src = '0; ch_dest = '0; ch_len = '0;
    dma_busy = 1'b0; dma_done = 1'b0;

    // Reset state
    tick(); tick();
    chk_idle_outs("rst");
    chk("rst_src",  64'(dma_src),  64'h0);
    chk("rst_dest", 64'(dma_dest), 64'h0);
    chk("rst_len",  64'(dma_len),  64'h0);
    rst = 1'b0;

    // dma_done outside WAIT_DONE is ignored
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();
    chk("stray_done_busy", 64'(arb_busy), 64'h0);
    chk("stray_done_chd",  64'(ch_done),  64'h0);

    // Single request on ch1
    ch_src[1*AW +: AW] = 32'h100;
    ch_dest[1*AW +: AW] = 32'h200;
    ch_len[1*LW +: LW] = 32'd3;
    ch_req = 4'b0010;
    tick();  // ISSUE
    chk("s1_grant", 64'(ch_grant), 64'h2);
    chk("s1_start", 64'(dma_start), 64'h1);
    chk("s1_src",   64'(dma_src),  64'h100);
    chk("s1_dest",  64'(dma_dest), 64'h200);
    chk("s1_len",   64'(dma_len),  64'h3);
    chk("s1_abusy", 64'(arb_busy), 64'h1);
    ch_src[1*AW +: AW] = 32'hdead;  // must not disturb in-flight transfer
    tick();  // WAIT_DONE
    chk("s1_start_off", 64'(dma_start), 64'h0);
    chk("s1_grant_hold", 64'(ch_grant), 64'h2);
    chk("s1_src_hold", 64'(dma_src), 64'h100);
    chk("s1_no_done", 64'(ch_done), 64'h0);
    dma_done = 1'b1;
    tick();  // COMPLETE
    dma_done = 1'b0;
    chk("s1_done", 64'(ch_done), 64'h2);
    chk("s1_err",  64'(ch_err),  64'h0);
    ch_req = '0;
    tick();  // IDLE
    chk_idle_outs("s1_end");

    // Round robin from reset: all four request len=1 continuously
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      ch_len[c*LW +: LW] = 32'd1;
      ch_src[c*AW +: AW] = 32'h1000 + 32'(c);
    end
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();  // ISSUE
      chk("rr_grant", 64'(ch_grant), 64'(1) << (k % NCH));
      chk("rr_src",   64'(dma_src),  64'h1000 + 64'(k % NCH));
      tick();  // WAIT_DONE
      dma_done = 1'b1;
      tick();  // COMPLETE
      dma_done = 1'b0;
      chk("rr_done", 64'(ch_done), 64'(1) << (k % NCH));
      tick();  // IDLE
      chk("rr_idle_grant", 64'(ch_grant), 64'h0);
    end
    ch_req = '0;
    tick(); tick();

    // Zero length on ch2: no start, done+err together
    do_reset();
    ch_len[2*LW +: LW] = 32'd0;
    ch_req = 4'b0100;
    tick();  // COMPLETE directly
    chk("z_grant", 64'(ch_grant), 64'h4);
    chk("z_start", 64'(dma_start), 64'h0);
    chk("z_done",  64'(ch_done), 64'h4);
    chk("z_err",   64'(ch_err),  64'h4);
    ch_req = '0;
    tick();
    chk_idle_outs("z_end");

    // Engine busy guard
    dma_busy = 1'b1;
    ch_len[0 +: LW] = 32'd5;
    ch_req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bz_grant", 64'(ch_grant), 64'h0);
      chk("bz_start", 64'(dma_start), 64'h0);
    end
    dma_busy = 1'b0;
    tick();
    chk("bz_grant_go", 64'(ch_grant), 64'h1);
    chk("bz_start_go", 64'(dma_start), 64'h1);
    chk("bz_len", 64'(dma_len), 64'h5);
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("bz_done", 64'(ch_done), 64'h1);
    ch_req = '0;
    tick();

    // Reset mid-transfer
    ch_req = 4'b0001;
    tick();  // ISSUE
    tick();  // WAIT_DONE
    chk("mr_grant", 64'(ch_grant), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk_idle_outs("mr_async");
    ch_req = '0;
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("mr_no_done", 64'(ch_done), 64'h0);
    rst = 1'b0;
    ch_len[3*LW +: LW] = 32'd2;
    ch_req = 4'b1000;
    tick();
    chk("mr_ch3_grant", 64'(ch_grant), 64'h8);
    chk("mr_ch3_start", 64'(dma_start), 64'h1);
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    chk("mr_ch3_done", 64'(ch_done), 64'h8);
    ch_req = '0;
    tick();

`ifdef DMA_ARB_TIMEOUT_EN
    // Watchdog: no dma_done, TIMEOUT_CYC=16
    do_reset();
    ch_req = 4'b0010;
    tick();  // ISSUE
    tick();  // WAIT_DONE, cycle 1
    for (int k = 0; k < 15; k++) tick();  // WAIT_DONE cycles 2..16
    chk("to_pre_done", 64'(ch_done), 64'h0);
    chk("to_pre_grant", 64'(ch_grant), 64'h2);
    tick();  // COMPLETE
    chk("to_done", 64'(ch_done), 64'h2);
    chk("to_err",  64'(ch_err),  64'h2);
    ch_req = '0;
    tick();
    chk_idle_outs("to_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
